// File: rtl/trigger_wait_controller.sv
// Purpose : sequences trigger-synchronizer enables for a "wait for trigger" op:
//           enable the selected channels, flush stale pulses, then wait for the
//           first qualifying pulse, a timeout or an abort.
// Latency : busy/trig_enable one edge after acceptance; FLUSH_CYCLES of flush;
//           done one edge after the terminating event (hit, timeout, abort).
// Backpressure: none; wait_req is honoured only in IDLE and is never queued.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   wait_req            start strobe (IDLE only); wait_mask/wait_timeout captured with it
//   abort               ends an active wait (FLUSH or WAIT) with status 10
//   trig_pulse          synchronized single-cycle pulses, one per channel
//   trig_enable         synchronizer enables (captured mask while busy, else 0)
//   busy                high from acceptance until the DONE cycle
//   done                one-cycle completion strobe
//   status              00 hit, 01 timeout, 10 abort
//   hit_channel         lowest qualifying channel index (0 unless hit)
//   hit_mask            all qualifying pulses in the hit cycle (0 unless hit)
//   elapsed             WAIT cycles counted before completion, saturating
module trigger_wait_controller #(
    parameter int NCHAN         = 8,
    parameter int CHAN_WIDTH    = 3,
    parameter int TIMEOUT_WIDTH = 32,
    parameter int FLUSH_CYCLES  = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wait_req,
    input  logic [NCHAN-1:0]         wait_mask,
    input  logic [TIMEOUT_WIDTH-1:0] wait_timeout,
    input  logic                     abort,
    input  logic [NCHAN-1:0]         trig_pulse,
    output logic [NCHAN-1:0]         trig_enable,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               status,
    output logic [CHAN_WIDTH-1:0]    hit_channel,
    output logic [NCHAN-1:0]         hit_mask,
    output logic [TIMEOUT_WIDTH-1:0] elapsed
);

    // Flush counter must hold the value FLUSH_CYCLES itself.
    localparam int FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] STATUS_HIT     = 2'b00;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
    localparam logic [1:0] STATUS_ABORT   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                   state_q,       state_d;
    logic [NCHAN-1:0]         mask_q,        mask_d;
    logic [TIMEOUT_WIDTH-1:0] timeout_q,     timeout_d;
    logic [FCW-1:0]           flush_cnt_q,   flush_cnt_d;
    logic [TIMEOUT_WIDTH-1:0] elapsed_q,     elapsed_d;
    logic [1:0]               status_q,      status_d;
    logic [CHAN_WIDTH-1:0]    hit_channel_q, hit_channel_d;
    logic [NCHAN-1:0]         hit_mask_q,    hit_mask_d;
    logic                     busy_q,        busy_d;
    logic                     done_q,        done_d;
    logic [NCHAN-1:0]         trig_en_q,     trig_en_d;

    logic [NCHAN-1:0]         qual;
    logic [CHAN_WIDTH-1:0]    low_idx;
    logic                     timeout_hit;

    assign qual = trig_pulse & mask_q;

    // Lowest set index wins: scan from the top so lower indices overwrite.
    always_comb begin
        low_idx = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (qual[i]) begin
                low_idx = CHAN_WIDTH'(i);
            end
        end
    end

    // A zero timeout means wait forever.
    assign timeout_hit = (timeout_q != '0) &&
                         (elapsed_q == (timeout_q - TIMEOUT_WIDTH'(1)));

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        timeout_d     = timeout_q;
        flush_cnt_d   = flush_cnt_q;
        elapsed_d     = elapsed_q;
        status_d      = status_q;
        hit_channel_d = hit_channel_q;
        hit_mask_d    = hit_mask_q;

        unique case (state_q)
            ST_IDLE: begin
                if (wait_req && !abort) begin
                    mask_d        = wait_mask;
                    timeout_d     = wait_timeout;
                    flush_cnt_d   = FCW'(FLUSH_CYCLES);
                    elapsed_d     = '0;
                    status_d      = STATUS_HIT;
                    hit_channel_d = '0;
                    hit_mask_d    = '0;
                    state_d       = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                // Pulses here are stale pipeline contents and are dropped.
                if (abort) begin
                    status_d = STATUS_ABORT;
                    state_d  = ST_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q - FCW'(1);
                    if (flush_cnt_q == FCW'(1)) begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                // Priority: abort, then hit, then timeout.
                if (abort) begin
                    status_d = STATUS_ABORT;
                    state_d  = ST_DONE;
                end else if (qual != '0) begin
                    status_d      = STATUS_HIT;
                    hit_mask_d    = qual;
                    hit_channel_d = low_idx;
                    state_d       = ST_DONE;
                end else if (timeout_hit) begin
                    status_d = STATUS_TIMEOUT;
                    state_d  = ST_DONE;
                end else if (elapsed_q != '1) begin
                    elapsed_d = elapsed_q + TIMEOUT_WIDTH'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d    = (state_d == ST_FLUSH) || (state_d == ST_WAIT);
        done_d    = (state_d == ST_DONE);
        trig_en_d = busy_d ? mask_d : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mask_q        <= '0;
            timeout_q     <= '0;
            flush_cnt_q   <= '0;
            elapsed_q     <= '0;
            status_q      <= '0;
            hit_channel_q <= '0;
            hit_mask_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            trig_en_q     <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            timeout_q     <= timeout_d;
            flush_cnt_q   <= flush_cnt_d;
            elapsed_q     <= elapsed_d;
            status_q      <= status_d;
            hit_channel_q <= hit_channel_d;
            hit_mask_q    <= hit_mask_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            trig_en_q     <= trig_en_d;
        end
    end

    assign trig_enable = trig_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign status      = status_q;
    assign hit_channel = hit_channel_q;
    assign hit_mask    = hit_mask_q;
    assign elapsed     = elapsed_q;

endmodule

// File: tb/tb_trigger_wait_controller.sv
// Purpose : randomized + directed bench for trigger_wait_controller with a
//           queue scoreboard; a monitor pops expected results on each done.
// Latency : request edge E0, done expected after edge E0 + c (c = terminating cycle).
// Backpressure: none; stimulus is driven just after each rising edge.
module tb_trigger_wait_controller;

    localparam int F = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wait_req = 1'b0;
    logic [7:0]  wait_mask = '0;
    logic [31:0] wait_timeout = '0;
    logic        abort = 1'b0;
    logic [7:0]  trig_pulse = '0;
    logic [7:0]  trig_enable;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [2:0]  hit_channel;
    logic [7:0]  hit_mask;
    logic [31:0] elapsed;

    trigger_wait_controller #(
        .NCHAN(8), .CHAN_WIDTH(3), .TIMEOUT_WIDTH(32), .FLUSH_CYCLES(F)
    ) dut (
        .clock(clock), .reset(reset), .wait_req(wait_req), .wait_mask(wait_mask),
        .wait_timeout(wait_timeout), .abort(abort), .trig_pulse(trig_pulse),
        .trig_enable(trig_enable), .busy(busy), .done(done), .status(status),
        .hit_channel(hit_channel), .hit_mask(hit_mask), .elapsed(elapsed)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  st;
        logic [2:0]  ch;
        logic [7:0]  hm;
        logic [31:0] el;
        int          edge_no;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] cur_mask = '0;

    // Per-cycle plan of a wait, indexed by cycle number (0 = request cycle).
    logic [7:0] pul [0:79];
    bit         ab  [0:79];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: checks enables while busy and pops one expectation per done.
    always @(negedge clock) begin
        if (!reset) begin
            if (busy) chk("trig_enable_busy", {24'd0, trig_enable}, {24'd0, cur_mask});
            if (done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: done=1 with empty scoreboard (t=%0t)", $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("status",      {30'd0, status},      {30'd0, mon_e.st});
                    chk("hit_channel", {29'd0, hit_channel}, {29'd0, mon_e.ch});
                    chk("hit_mask",    {24'd0, hit_mask},    {24'd0, mon_e.hm});
                    chk("elapsed",     elapsed,              mon_e.el);
                    chk("done_edge",   cyc,                  mon_e.edge_no);
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                    chk("trig_en_at_done", {24'd0, trig_enable}, 32'd0);
                end
            end
        end
    end

    task automatic clear_plan();
        for (int n = 0; n < 80; n++) begin
            pul[n] = '0;
            ab[n]  = 1'b0;
        end
    endtask

    // Reference: walk the plan cycle by cycle using the behavioural rules.
    // Cycles 1..F are flush cycles; cycle F+1+w is WAIT cycle w.
    task automatic model(input logic [7:0] m, input logic [31:0] t,
                         output int c, output exp_t e);
        int w;
        logic [7:0] q;
        e.st = 2'b00; e.ch = '0; e.hm = '0; e.el = '0; e.edge_no = 0;
        c = 0;
        for (int n = 1; n < 80; n++) begin
            w = n - F - 1;
            q = pul[n] & m;
            if (n <= F) begin
                if (ab[n]) begin e.st = 2'b10; c = n; break; end
            end else if (ab[n]) begin
                e.st = 2'b10; e.el = w; c = n; break;
            end else if (q != 0) begin
                e.st = 2'b00; e.hm = q; e.el = w;
                for (int i = 7; i >= 0; i--) if (q[i]) e.ch = 3'(i);
                c = n; break;
            end else if (t != 0 && w == int'(t) - 1) begin
                e.st = 2'b01; e.el = w; c = n; break;
            end
        end
    endtask

    // Drives one wait from request through its DONE cycle, then leaves the
    // bench at the start of the following (IDLE) cycle.
    task automatic run(input logic [7:0] m, input logic [31:0] t, input bit noise);
        int   c;
        exp_t e;
        model(m, t, c, e);
        e.edge_no = cyc + 1 + c;
        sb.push_back(e);
        cur_mask     = m;
        wait_req     = 1'b1;
        wait_mask    = m;
        wait_timeout = t;
        abort        = 1'b0;
        trig_pulse   = pul[0];
        for (int n = 1; n <= c + 1; n++) begin
            @(posedge clock); #1;
            wait_req     = noise ? 1'($urandom) : 1'b0;
            wait_mask    = 8'($urandom);
            wait_timeout = 32'($urandom_range(0, 3));
            abort        = (n <= c) ? ab[n] : (noise ? 1'($urandom) : 1'b0);
            trig_pulse   = (n <= c) ? pul[n] : 8'($urandom);
        end
        @(posedge clock); #1;
        wait_req   = 1'b0;
        abort      = 1'b0;
        trig_pulse = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},        {31'd0, busy},        32'd0);
        chk({tag, "_done"},        {31'd0, done},        32'd0);
        chk({tag, "_trig_enable"}, {24'd0, trig_enable}, 32'd0);
        chk({tag, "_status"},      {30'd0, status},      32'd0);
        chk({tag, "_hit_channel"}, {29'd0, hit_channel}, 32'd0);
        chk({tag, "_hit_mask"},    {24'd0, hit_mask},    32'd0);
        chk({tag, "_elapsed"},     elapsed,              32'd0);
    endtask

    task automatic reset_mid_wait();
        clear_plan();
        cur_mask     = 8'hFF;
        wait_req     = 1'b1;
        wait_mask    = 8'hFF;
        wait_timeout = 32'd0;
        repeat (F + 3) begin
            @(posedge clock); #1;
            wait_req = 1'b0;
        end
        // Now in WAIT cycle 2: elapsed is non-zero, so clearing is observable.
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        chk("elapsed_before_reset", elapsed, 32'd2);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        cur_mask = '0;
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic rand_plan(output logic [7:0] m, output logic [31:0] t);
        int sel;
        clear_plan();
        sel = $urandom_range(0, 9);
        m = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
        t = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 25));
        for (int n = 0; n < 80; n++) begin
            pul[n] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            ab[n]  = ($urandom_range(0, 29) == 0);
        end
        ab[0]  = 1'b0;
        ab[60] = 1'b1;  // bounds every wait, including mask 0 / timeout 0
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rm;
        logic [31:0] rt;
        #2 check_all_zero("reset");
        #20 reset = 1'b0;
        @(posedge clock); #1;

        // Hit on ch2 at WAIT cycle 7; masked-out and flush pulses ignored.
        clear_plan();
        pul[1] = 8'h01; pul[F + 1 + 2] = 8'h02; pul[F + 1 + 7] = 8'h04;
        run(8'h05, 32'd100, 1'b0);

        // Pulse in the 2nd flush cycle is discarded; wait times out.
        clear_plan();
        pul[2] = 8'h01;
        run(8'h01, 32'd10, 1'b0);

        // Lowest qualifying channel wins; ch4 is outside the mask.
        clear_plan();
        pul[F + 1] = 8'h1A;
        run(8'h0A, 32'd50, 1'b0);

        // Hit coincides with the timeout cycle.
        clear_plan();
        pul[F + 1 + 4] = 8'h08;
        run(8'h08, 32'd5, 1'b0);

        // Abort beats a simultaneous hit; wait_req noise while busy/DONE.
        clear_plan();
        pul[F + 1 + 2] = 8'h20; ab[F + 1 + 2] = 1'b1;
        run(8'hFF, 32'd0, 1'b1);

        // Accepted in the cycle right after DONE; aborted during flush.
        clear_plan();
        ab[2] = 1'b1;
        run(8'hFF, 32'd0, 1'b0);

        // Timeout of 1: done on the very first WAIT cycle.
        clear_plan();
        run(8'h00, 32'd1, 1'b0);

        reset_mid_wait();
        clear_plan();
        pul[F + 1 + 3] = 8'h80;
        run(8'hC0, 32'd20, 1'b0);

        for (int k = 0; k < 40; k++) begin
            rand_plan(rm, rt);
            run(rm, rt, ($urandom_range(0, 1) == 1));
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clock);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL missing_done: %0d expected completions outstanding", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
